alu_seq: RTL and testbench
==========================

# alu_seq

Sequential, parametrised successor to the combinational execute-stage ALU. Keeps the existing 5-bit opcode map (arithmetic, logic, MVHI, compare) and adds shifts plus iterative multiply, divide and remainder. Uses valid/ready handshakes on both sides so the pipeline can stall on multi-cycle ops. Sits in EX between the ID/EX register and the EX/MEM register; it owns its own output register.

## Interface
- BIT_WIDTH, 32: operand/result width; even, ≥8
- OP_BITS, 5: opcode width
- TAG_BITS, 5: sideband tag (destination register index) carried with each op
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode/tag valid
- in_ready  out  1  block accepts op this cycle
- operand1, operand2  in  BIT_WIDTH  signed operands
- alu_op  in  OP_BITS  opcode
- in_tag  in  TAG_BITS  tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- alu_out  out  BIT_WIDTH  result
- cond_flag  out  1  compare outcome
- out_tag  out  TAG_BITS  tag of the result
- div_by_zero  out  1  DIV/REM with operand2==0
- illegal_op  out  1  undefined (or compiled-out) opcode
- busy  out  1  iterative op in progress

## Operation
- Opcodes 00000–10000 keep existing meaning: ADD, SUB, AND, OR, XOR, NAND, NOR, XNOR, MVHI, F, EQ, LT, LTE, T, NE, GTE, GT. Signed compares; compares drive alu_out = cond_flag zero-extended; non-compares drive cond_flag=0.
- MVHI: alu_out[W-1:W/2]=operand2[W/2-1:0], low half 0.
- New: 10001 SLL, 10010 SRL, 10011 SRA (amount = operand2[$clog2(W)-1:0]); 10100 MUL (low W bits of product); 10101 DIV (signed, truncate toward zero); 10110 REM (sign of dividend).
- DIV/REM by zero: DIV → all ones, REM → operand1, div_by_zero=1. DIV of most-negative by −1 → most-negative; REM → 0; no flag.
- Undefined opcodes: alu_out=0, cond_flag=0, illegal_op=1; single-cycle.
- FSM: IDLE → (accept single-cycle op) DONE; IDLE → (accept MUL/DIV/REM) BUSY; BUSY → DONE after BIT_WIDTH iteration cycles (shift-add / restoring divide, one bit per cycle); DONE → IDLE when out_ready and no new accept; DONE → DONE/BUSY when out_ready and new accept same cycle.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready). Operands and tag latched at accept; input changes afterwards ignored.
- out_valid = (state==DONE). alu_out, cond_flag, out_tag, div_by_zero, illegal_op held stable while out_valid & !out_ready.
- busy = (state==BUSY).

## Timing
- Reset: state IDLE; out_valid=0, alu_out=0, cond_flag=0, out_tag=0, div_by_zero=0, illegal_op=0, busy=0, in_ready=1 the cycle after reset deasserts (0 while reset high). Reset mid-BUSY or mid-DONE discards the op, no result emitted.
- Single-cycle ops: accept at edge N → out_valid high after edge N (visible cycle N+1).
- MUL/DIV/REM: accept at edge N → busy for cycles N+1..N+W → out_valid visible cycle N+W+1.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- out_valid never drops without out_ready.

## Configuration
- ALU_DIV_EN defined: DIV/REM implemented as above.
- Not defined: divider logic absent; DIV/REM treated as undefined opcodes (single-cycle, alu_out=0, illegal_op=1, div_by_zero=0). MUL unaffected.

## Test plan
- Reset held 2 cycles mid-MUL → all outputs 0, busy=0, no out_valid; next ADD 5+7 → alu_out=12 one cycle after accept.
- SUB 3−10 with out_ready=0 for 3 cycles → alu_out=0xFFFFFFF9 stable, in_ready=0 until out_ready=1; LT(−1,1) → cond_flag=1, alu_out=1.
- MUL −3×7, tag 9 → busy 32 cycles, alu_out=0xFFFFFFEB, out_tag=9 on cycle 33 after accept.
- DIV −7/2 → −3; REM −7/2 → −1; DIV 5/0 → 0xFFFFFFFF, div_by_zero=1; DIV 0x80000000/−1 → 0x80000000 (ALU_DIV_EN defined); macro undefined → DIV gives illegal_op=1, alu_out=0 one cycle later.
- SRA 0x80000000 by 4 → 0xF8000000; SLL 1 by 33 → 0x2 (amount masked); MVHI op2=0x1234 → 0x12340000.
- Opcode 11111 → illegal_op=1, alu_out=0; 20 random single-cycle ops with random out_ready → results in order, none dropped or duplicated.

Source files
------------

// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq                                                       |
// | Purpose  : Sequential execute-stage ALU. Single-cycle arithmetic, logic, |
// |            MVHI, signed compares and shifts; iterative MUL (shift-add)   |
// |            and, when ALU_DIV_EN is defined, iterative signed DIV/REM     |
// |            (restoring, one quotient bit per cycle). Valid/ready on both  |
// |            sides; the result sits in an owned output register.           |
// | Macro    : ALU_DIV_EN - builds the divider. Undefined: DIV/REM decode as |
// |            illegal single-cycle opcodes.                                 |
// | Ports    : clk, reset (sync, active high)                                |
// |            in_valid/in_ready, operand1, operand2, alu_op, in_tag         |
// |            out_valid/out_ready, alu_out, cond_flag, out_tag,             |
// |            div_by_zero, illegal_op, busy                                 |
// | Revision : 1.0 - initial sequential release                              |
// +--------------------------------------------------------------------------+
module alu_seq #(
    parameter int BIT_WIDTH = 32,
    parameter int OP_BITS   = 5,
    parameter int TAG_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] operand1,
    input  logic [BIT_WIDTH-1:0] operand2,
    input  logic [OP_BITS-1:0]   alu_op,
    input  logic [TAG_BITS-1:0]  in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] alu_out,
    output logic                 cond_flag,
    output logic [TAG_BITS-1:0]  out_tag,
    output logic                 div_by_zero,
    output logic                 illegal_op,
    output logic                 busy
);

    localparam int c_SH_W   = $clog2(BIT_WIDTH);
    localparam int c_HALF   = BIT_WIDTH / 2;
    localparam int c_CNT_W  = $clog2(BIT_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIT_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [OP_BITS-1:0] c_OP_ADD  = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] c_OP_SUB  = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] c_OP_AND  = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] c_OP_OR   = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] c_OP_XOR  = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] c_OP_NAND = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] c_OP_NOR  = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] c_OP_XNOR = OP_BITS'(7);
    localparam logic [OP_BITS-1:0] c_OP_MVHI = OP_BITS'(8);
    localparam logic [OP_BITS-1:0] c_OP_F    = OP_BITS'(9);
    localparam logic [OP_BITS-1:0] c_OP_EQ   = OP_BITS'(10);
    localparam logic [OP_BITS-1:0] c_OP_LT   = OP_BITS'(11);
    localparam logic [OP_BITS-1:0] c_OP_LTE  = OP_BITS'(12);
    localparam logic [OP_BITS-1:0] c_OP_T    = OP_BITS'(13);
    localparam logic [OP_BITS-1:0] c_OP_NE   = OP_BITS'(14);
    localparam logic [OP_BITS-1:0] c_OP_GTE  = OP_BITS'(15);
    localparam logic [OP_BITS-1:0] c_OP_GT   = OP_BITS'(16);
    localparam logic [OP_BITS-1:0] c_OP_SLL  = OP_BITS'(17);
    localparam logic [OP_BITS-1:0] c_OP_SRL  = OP_BITS'(18);
    localparam logic [OP_BITS-1:0] c_OP_SRA  = OP_BITS'(19);
    localparam logic [OP_BITS-1:0] c_OP_MUL  = OP_BITS'(20);
    localparam logic [OP_BITS-1:0] c_OP_DIV  = OP_BITS'(21);
    localparam logic [OP_BITS-1:0] c_OP_REM  = OP_BITS'(22);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_accept;
    logic                 w_is_iter;
    logic                 w_last;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [BIT_WIDTH-1:0] r_alu_out;
    logic                 r_cond;
    logic [TAG_BITS-1:0]  r_out_tag;
    logic                 r_dbz;
    logic                 r_ill;
    logic [TAG_BITS-1:0]  r_tag;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic signed [BIT_WIDTH-1:0] w_sa;
    logic signed [BIT_WIDTH-1:0] w_sb;
    logic [c_SH_W-1:0]           w_shamt;
    logic [BIT_WIDTH-1:0]        w_sc_out;
    logic                        w_cmp;
    logic                        w_is_cmp;
    logic                        w_sc_ill;

    assign w_sa    = $signed(operand1);
    assign w_sb    = $signed(operand2);
    assign w_shamt = operand2[c_SH_W-1:0];

    always_comb begin
        w_sc_out = '0;
        w_cmp    = 1'b0;
        w_is_cmp = 1'b0;
        w_sc_ill = 1'b0;
        case (alu_op)
            c_OP_ADD:  w_sc_out = operand1 + operand2;
            c_OP_SUB:  w_sc_out = operand1 - operand2;
            c_OP_AND:  w_sc_out = operand1 & operand2;
            c_OP_OR:   w_sc_out = operand1 | operand2;
            c_OP_XOR:  w_sc_out = operand1 ^ operand2;
            c_OP_NAND: w_sc_out = ~(operand1 & operand2);
            c_OP_NOR:  w_sc_out = ~(operand1 | operand2);
            c_OP_XNOR: w_sc_out = ~(operand1 ^ operand2);
            c_OP_MVHI: w_sc_out = {operand2[c_HALF-1:0], {c_HALF{1'b0}}};
            c_OP_F:    w_is_cmp = 1'b1;
            c_OP_EQ:   begin w_is_cmp = 1'b1; w_cmp = (operand1 == operand2); end
            c_OP_LT:   begin w_is_cmp = 1'b1; w_cmp = (w_sa <  w_sb);         end
            c_OP_LTE:  begin w_is_cmp = 1'b1; w_cmp = (w_sa <= w_sb);         end
            c_OP_T:    begin w_is_cmp = 1'b1; w_cmp = 1'b1;                   end
            c_OP_NE:   begin w_is_cmp = 1'b1; w_cmp = (operand1 != operand2); end
            c_OP_GTE:  begin w_is_cmp = 1'b1; w_cmp = (w_sa >= w_sb);         end
            c_OP_GT:   begin w_is_cmp = 1'b1; w_cmp = (w_sa >  w_sb);         end
            c_OP_SLL:  w_sc_out = operand1 << w_shamt;
            c_OP_SRL:  w_sc_out = operand1 >> w_shamt;
            c_OP_SRA:  w_sc_out = w_sa >>> w_shamt;
            // MUL always takes the iterative path; this result is never used.
            c_OP_MUL:  w_sc_out = '0;
            // Only reaches the output when the divider is compiled out.
            c_OP_DIV,
            c_OP_REM:  w_sc_ill = 1'b1;
            default:   w_sc_ill = 1'b1;
        endcase
        if (w_is_cmp) begin
            w_sc_out = {{(BIT_WIDTH-1){1'b0}}, w_cmp};
        end
    end

`ifdef ALU_DIV_EN
    assign w_is_iter = (alu_op == c_OP_MUL) | (alu_op == c_OP_DIV) | (alu_op == c_OP_REM);
`else
    assign w_is_iter = (alu_op == c_OP_MUL);
`endif

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == c_ST_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_iter ? c_ST_BUSY : c_ST_DONE;
                end
            end
            c_ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // An accept here implies out_ready, so the result is consumed.
                if (w_accept) begin
                    w_state_nxt = w_is_iter ? c_ST_BUSY : c_ST_DONE;
                end else if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: in_ready = ~reset;
            c_ST_BUSY: busy = 1'b1;
            c_ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = ~reset & out_ready;
            end
            default: ;
        endcase
    end

    // Iteration counter: loaded with W-1 at accept so the final
    // iteration (count 0) lands on the W-th edge after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_tag <= '0;
        end else if (w_accept & w_is_iter) begin
            r_cnt <= c_CNT_LAST;
            r_tag <= in_tag;
        end else if (r_state == c_ST_BUSY) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier (low W bits are sign-agnostic)
    // ------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] r_mcand;
    logic [BIT_WIDTH-1:0] r_mplier;
    logic [BIT_WIDTH-1:0] r_acc;
    logic [BIT_WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (w_accept & w_is_iter) begin
            r_mcand  <= operand1;
            r_mplier <= operand2;
            r_acc    <= '0;
        end else if (r_state == c_ST_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    logic [BIT_WIDTH-1:0] w_it_out;
    logic                 w_it_dbz;

`ifdef ALU_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divider on magnitudes; signs applied on completion.
    // |most-negative| is representable as an unsigned W-bit value, so
    // most-negative / -1 falls out as most-negative with remainder 0.
    // ------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] r_quo;
    logic [BIT_WIDTH-1:0] r_rem;
    logic [BIT_WIDTH-1:0] r_dvsr;
    logic [BIT_WIDTH-1:0] r_dvnd;
    logic                 r_q_neg;
    logic                 r_r_neg;
    logic                 r_dz;
    logic                 r_is_div;
    logic                 r_is_rem;
    logic [BIT_WIDTH-1:0] w_abs1;
    logic [BIT_WIDTH-1:0] w_abs2;
    logic [BIT_WIDTH:0]   w_shift;
    logic [BIT_WIDTH:0]   w_diff;
    logic [BIT_WIDTH-1:0] w_quo_nxt;
    logic [BIT_WIDTH-1:0] w_rem_nxt;
    logic [BIT_WIDTH-1:0] w_div_q;
    logic [BIT_WIDTH-1:0] w_div_r;

    assign w_abs1    = operand1[BIT_WIDTH-1] ? -operand1 : operand1;
    assign w_abs2    = operand2[BIT_WIDTH-1] ? -operand2 : operand2;
    assign w_shift   = {r_rem, r_quo[BIT_WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_rem_nxt = w_diff[BIT_WIDTH] ? w_shift[BIT_WIDTH-1:0] : w_diff[BIT_WIDTH-1:0];
    assign w_quo_nxt = {r_quo[BIT_WIDTH-2:0], ~w_diff[BIT_WIDTH]};
    assign w_div_q   = r_dz ? '1     : (r_q_neg ? -w_quo_nxt : w_quo_nxt);
    assign w_div_r   = r_dz ? r_dvnd : (r_r_neg ? -w_rem_nxt : w_rem_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_dvnd   <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_accept & w_is_iter) begin
            r_quo    <= w_abs1;
            r_rem    <= '0;
            r_dvsr   <= w_abs2;
            r_dvnd   <= operand1;
            r_q_neg  <= operand1[BIT_WIDTH-1] ^ operand2[BIT_WIDTH-1];
            r_r_neg  <= operand1[BIT_WIDTH-1];
            r_dz     <= (operand2 == '0);
            r_is_div <= (alu_op == c_OP_DIV);
            r_is_rem <= (alu_op == c_OP_REM);
        end else if (r_state == c_ST_BUSY) begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    always_comb begin
        w_it_out = w_acc_nxt;
        w_it_dbz = 1'b0;
        if (r_is_div) begin
            w_it_out = w_div_q;
            w_it_dbz = r_dz;
        end else if (r_is_rem) begin
            w_it_out = w_div_r;
            w_it_dbz = r_dz;
        end
    end
`else
    assign w_it_out = w_acc_nxt;
    assign w_it_dbz = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output register: written only on a single-cycle accept or on the
    // final iteration, so it holds while a result waits for out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out <= '0;
            r_cond    <= 1'b0;
            r_out_tag <= '0;
            r_dbz     <= 1'b0;
            r_ill     <= 1'b0;
        end else if (w_accept & ~w_is_iter) begin
            r_alu_out <= w_sc_out;
            r_cond    <= w_cmp;
            r_out_tag <= in_tag;
            r_dbz     <= 1'b0;
            r_ill     <= w_sc_ill;
        end else if (w_last) begin
            r_alu_out <= w_it_out;
            r_cond    <= 1'b0;
            r_out_tag <= r_tag;
            r_dbz     <= w_it_dbz;
            r_ill     <= 1'b0;
        end
    end

    assign alu_out     = r_alu_out;
    assign cond_flag   = r_cond;
    assign out_tag     = r_out_tag;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                    |
// | Purpose  : Self-checking bench for alu_seq: scoreboard of expected       |
// |            results, vector table, hand sequences for multi-cycle cases.  |
// | Revision : 1.0 - initial                                                 |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_NAND = 5'd5, OP_NOR = 5'd6,  OP_XNOR = 5'd7;
    localparam logic [4:0] OP_MVHI = 5'd8, OP_F = 5'd9,    OP_EQ = 5'd10,  OP_LT = 5'd11;
    localparam logic [4:0] OP_LTE = 5'd12, OP_T = 5'd13,   OP_NE = 5'd14,  OP_GTE = 5'd15;
    localparam logic [4:0] OP_GT = 5'd16,  OP_SLL = 5'd17, OP_SRL = 5'd18, OP_SRA = 5'd19;
    localparam logic [4:0] OP_MUL = 5'd20, OP_DIV = 5'd21, OP_REM = 5'd22;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  alu_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        cond_flag;
    logic [4:0]  out_tag;
    logic        div_by_zero;
    logic        illegal_op;
    logic        busy;

    alu_seq #(.BIT_WIDTH(32), .OP_BITS(5), .TAG_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .alu_op(alu_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .cond_flag(cond_flag), .out_tag(out_tag),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] eout;
        logic        econd;
        logic        edbz;
        logic        eill;
    } vec_t;

    vec_t exp_q[$];
    vec_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rnd_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Random out_ready during the random phase; driven #2 after the edge.
    always @(posedge clk) begin
        #2;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: a handshake is visible at the negedge before the edge that takes it.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got out=%h tag=%0d with nothing pending", alu_out, out_tag);
            end else begin
                e = exp_q.pop_front();
                if (alu_out !== e.eout || cond_flag !== e.econd || out_tag !== e.tag ||
                    div_by_zero !== e.edbz || illegal_op !== e.eill) begin
                    fails++;
                    $display("FAIL result op=%0d a=%h b=%h: got out=%h cond=%b tag=%0d dbz=%b ill=%b, expected out=%h cond=%b tag=%0d dbz=%b ill=%b",
                             e.op, e.a, e.b, alu_out, cond_flag, out_tag, div_by_zero, illegal_op,
                             e.eout, e.econd, e.tag, e.edbz, e.eill);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] tag, input logic [31:0] eout,
                                input logic econd, input logic edbz, input logic eill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag;
        v.eout = eout; v.econd = econd; v.edbz = edbz; v.eill = eill;
        return v;
    endfunction

    // Reference model for single-cycle opcodes.
    function automatic vec_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        vec_t v;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a; sb = b;
        v = mk(op, a, b, tag, 32'h0, 1'b0, 1'b0, 1'b0);
        case (op)
            OP_ADD:  v.eout = a + b;
            OP_SUB:  v.eout = a - b;
            OP_AND:  v.eout = a & b;
            OP_OR:   v.eout = a | b;
            OP_XOR:  v.eout = a ^ b;
            OP_NAND: v.eout = ~(a & b);
            OP_NOR:  v.eout = ~(a | b);
            OP_XNOR: v.eout = ~(a ^ b);
            OP_MVHI: v.eout = {b[15:0], 16'h0000};
            OP_F:    v.econd = 1'b0;
            OP_EQ:   v.econd = (a == b);
            OP_LT:   v.econd = (sa < sb);
            OP_LTE:  v.econd = (sa <= sb);
            OP_T:    v.econd = 1'b1;
            OP_NE:   v.econd = (a != b);
            OP_GTE:  v.econd = (sa >= sb);
            OP_GT:   v.econd = (sa > sb);
            OP_SLL:  v.eout = a << b[4:0];
            OP_SRL:  v.eout = a >> b[4:0];
            OP_SRA:  v.eout = sa >>> b[4:0];
            default: v.eill = 1'b1;
        endcase
        if (op >= OP_F && op <= OP_GT) v.eout = {31'b0, v.econd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, "_alu_out"}, alu_out, 32'h0);
        chk({name, "_cond_flag"}, {31'b0, cond_flag}, 32'h0);
        chk({name, "_out_tag"}, {27'b0, out_tag}, 32'h0);
        chk({name, "_div_by_zero"}, {31'b0, div_by_zero}, 32'h0);
        chk({name, "_illegal_op"}, {31'b0, illegal_op}, 32'h0);
        chk({name, "_busy"}, {31'b0, busy}, 32'h0);
        chk({name, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic issue(input vec_t v);
        int g;
        g = 0;
        in_valid = 1'b1; alu_op = v.op; operand1 = v.a; operand2 = v.b; in_tag = v.tag;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout op=%0d: in_ready got 0 expected 1", v.op);
        end else begin
            exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        operand1 = $urandom; operand2 = $urandom; alu_op = 5'($urandom); in_tag = 5'($urandom);
    endtask

    // Called right after issue(); counts busy cycles until out_valid.
    task automatic check_latency(input int exp_busy, input string name);
        int n;
        int nb;
        n = 0; nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (busy) nb++;
        end
        tests++;
        if (!out_valid || nb != exp_busy || n != exp_busy + 1) begin
            fails++;
            $display("FAIL latency_%s: got valid_at=%0d busy=%0d expected valid_at=%0d busy=%0d",
                     name, n, nb, exp_busy + 1, exp_busy);
        end
        step();
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk({"drain_", name}, exp_q.size(), 32'h0);
        step();
    endtask

    vec_t tbl[20];
    vec_t dv[6];

    initial begin : main
        int t0;
        int nv;
        logic [4:0] rop;
        int r;

        tbl[0]  = mk(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd1,  32'h00000000, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd2,  32'hF000F000, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(OP_OR,   32'hF0F0F0F0, 32'h0F00000F, 5'd3,  32'hFFF0F0FF, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd4,  32'hF0F00F0F, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(OP_NAND, 32'hFFFFFFFF, 32'h0000FFFF, 5'd5,  32'hFFFF0000, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(OP_NOR,  32'h00000000, 32'h00000000, 5'd6,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(OP_XNOR, 32'h12345678, 32'h12345678, 5'd7,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(OP_MVHI, 32'hDEADBEEF, 32'h00001234, 5'd8,  32'h12340000, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(OP_F,    32'h00000001, 32'h00000001, 5'd9,  32'h00000000, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(OP_EQ,   32'h00000005, 32'h00000005, 5'd10, 32'h00000001, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(OP_LTE,  32'h80000000, 32'h7FFFFFFF, 5'd11, 32'h00000001, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(OP_T,    32'h00000000, 32'h00000000, 5'd12, 32'h00000001, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(OP_NE,   32'h00000003, 32'h00000003, 5'd13, 32'h00000000, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(OP_GTE,  32'hFFFFFFFF, 32'h00000000, 5'd14, 32'h00000000, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(OP_GT,   32'h00000001, 32'hFFFFFFFF, 5'd15, 32'h00000001, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(OP_SLL,  32'h00000001, 32'h00000021, 5'd16, 32'h00000002, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(OP_SRL,  32'h80000000, 32'h00000004, 5'd17, 32'h08000000, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(OP_SRA,  32'h80000000, 32'h00000004, 5'd18, 32'hF8000000, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(5'd31,   32'h00000001, 32'h00000002, 5'd19, 32'h00000000, 1'b0, 1'b0, 1'b1);
        tbl[19] = mk(5'd23,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1'b0, 1'b0, 1'b1);

        dv[0] = mk(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 5'd21, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        dv[1] = mk(OP_REM, 32'hFFFFFFF9, 32'h00000002, 5'd22, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        dv[2] = mk(OP_DIV, 32'h00000005, 32'h00000000, 5'd23, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        dv[3] = mk(OP_REM, 32'h00000005, 32'h00000000, 5'd24, 32'h00000005, 1'b0, 1'b1, 1'b0);
        dv[4] = mk(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd25, 32'h80000000, 1'b0, 1'b0, 1'b0);
        dv[5] = mk(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'h00000000, 1'b0, 1'b0, 1'b0);

        // Reset state
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; operand1 = '0; operand2 = '0; in_tag = '0;
        step(); step();
        @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_in_ready", {31'b0, in_ready}, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'h1);
        step();

        // Reset in the middle of a MUL discards it
        in_valid = 1'b1; alu_op = OP_MUL; operand1 = 32'd3; operand2 = 32'd4; in_tag = 5'd1;
        @(negedge clk);
        chk("mid_mul_accept", {31'b0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("mid_mul_busy", {31'b0, busy}, 32'h1);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk_idle_zero("mid_mul_reset");
        step();
        reset = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("mid_mul_no_result", nv, 32'h0);
        step();

        issue(mk(OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b0, 1'b0));
        check_latency(0, "add");

        // Backpressure: result held, no accept until out_ready
        out_ready = 1'b0;
        issue(mk(OP_SUB, 32'd3, 32'd10, 5'd4, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0));
        repeat (3) begin
            @(negedge clk);
            chk("sub_hold_valid", {31'b0, out_valid}, 32'h1);
            chk("sub_hold_out", alu_out, 32'hFFFFFFF9);
            chk("sub_hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        step();
        out_ready = 1'b1;
        issue(mk(OP_LT, 32'hFFFFFFFF, 32'd1, 5'd5, 32'd1, 1'b1, 1'b0, 1'b0));
        check_latency(0, "lt");

        // MUL: W busy cycles, result the cycle after
        issue(mk(OP_MUL, 32'hFFFFFFFD, 32'd7, 5'd9, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0));
        check_latency(32, "mul");

`ifdef ALU_DIV_EN
        for (int i = 0; i < 6; i++) begin
            issue(dv[i]);
            check_latency(32, "divrem");
        end
`else
        for (int i = 0; i < 6; i++) begin
            issue(mk(dv[i].op, dv[i].a, dv[i].b, dv[i].tag, 32'h0, 1'b0, 1'b0, 1'b1));
            check_latency(0, "divrem_disabled");
        end
`endif
        drain("directed");

        // Vector table back-to-back: one result per cycle
        t0 = cyc;
        for (int i = 0; i < 20; i++) issue(tbl[i]);
        chk("table_throughput", cyc - t0, 32'd20);
        drain("table");

        // Random single-cycle ops with random out_ready
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 28);
            rop = (r < 20) ? 5'(r) : 5'(r + 3);
            issue(model(rop, $urandom, $urandom, 5'($urandom)));
        end
        rnd_en = 1'b0;
        step();
        out_ready = 1'b1;
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
